free_list: RTL
==============

FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 The block SHALL use these parameters from sys_defs: NUM_PHYS_REG = 64, meaning physical register count; NUM_GEN_REG = 32, meaning architectural register count; FL_DEPTH = NUM_PHYS_REG-NUM_GEN_REG = 32, meaning queue depth.
REQ-002 The block SHALL use the PHYS_REG encoding of 7 bits: bits [5:0] are the physical index; bit [6] is the ready bit.
REQ-003 clock  input  1  system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  dispatch requests a free register this cycle.
REQ-006 retire_en  input  1  ROB retires an instruction and releases its old tag this cycle.
REQ-007 retire_tag  input  PHYS_REG  old physical tag being released; bit [6] is ignored.
REQ-008 checkpoint_en  input  1  dispatch of a branch; snapshot the head pointer.
REQ-009 branch_incorrect  input  1  mispredict; restore the head pointer from the snapshot.
REQ-010 free_reg  output  PHYS_REG  tag at the queue head, with bit [6] = 0; drives the map table free_reg input.
REQ-011 free_valid  output  1  queue non-empty; free_reg is meaningful.
REQ-012 num_free  output  6  count of free entries, 0..32.

Function
REQ-013 The block SHALL be a circular FIFO of 32 entries, each holding a 6-bit index, with 6-bit head and tail pointers (5 address bits plus 1 wrap bit).
REQ-014 num_free SHALL equal tail-head modulo 64; free_valid SHALL equal (num_free != 0); both outputs are combinational from registered state.
REQ-015 free_reg SHALL equal {1'b0, entry[head]} combinationally, with zero-cycle latency from the head update.
REQ-016 A dequeue SHALL occur when enable=1, free_valid=1 and branch_incorrect=0; head advances by 1 at the clock edge.
REQ-017 enable=1 with free_valid=0 SHALL be ignored: no pointer change, free_reg not consumed, and no bypass of a same-cycle retire_tag.
REQ-018 retire_en=1 SHALL write retire_tag[5:0] at entry[tail] and advance tail by 1, regardless of enable and branch_incorrect.
REQ-019 Simultaneous dequeue and retire SHALL both take effect; num_free is unchanged.
REQ-020 retire_en=1 while num_free=32 is illegal: the state SHALL stay unchanged, and the `ifdef simulation assertion SHALL fire.
REQ-021 checkpoint_en=1 SHALL capture the head value after this cycle's dequeue into ckpt_head.
REQ-022 branch_incorrect=1 SHALL load head from ckpt_head at the edge; any enable is ignored; a same-cycle retire is still enqueued.
REQ-023 branch_incorrect and checkpoint_en in the same cycle: restore wins; ckpt_head is unchanged.
REQ-024 Pointer increments SHALL wrap 63->0 across the wrap bit; entries wrap index 31->0.

Reset
REQ-025 On reset, entry[i] SHALL be NUM_GEN_REG+i (32..63) for i = 0..31, matching the map table identity reset of reg_i -> pr_i.
REQ-026 On reset, head SHALL be 0, tail SHALL be 32 (wrap bit set), and ckpt_head SHALL be 0.
REQ-027 In the cycle after reset deasserts: free_reg=7'h20, free_valid=1, num_free=32.
REQ-028 Reset SHALL override all other inputs, including during a branch restore or a full/empty condition.

Configuration
REQ-029 Macro FREE_LIST_DEBUG_EN, when defined, SHALL add outputs fl_entries_out [31:0][5:0], head_out[5:0] and tail_out[5:0], mirroring internal state, and SHALL enable the REQ-020 assertion.
REQ-030 Without FREE_LIST_DEBUG_EN, these ports and the assertion SHALL be absent; functional behaviour is identical.

Verification
REQ-031 Reset, then enable=1 for 3 cycles -> free_reg sequence 32, 33, 34; num_free 32 -> 29.
REQ-032 From reset, enable=1 for 32 cycles -> num_free=0, free_valid=0; a further enable leaves head unchanged.
REQ-033 Empty queue, retire_tag=7'h45, with enable=1 in the same cycle -> no dequeue; next cycle free_reg=7'h05, num_free=1.
REQ-034 Full queue (after reset), dequeue and retire_tag=7'h03 in the same cycle -> num_free stays 32; after 31 further dequeues, free_reg=7'h03.
REQ-035 checkpoint_en with enable at head=2, then dequeue 4, then branch_incorrect with retire of 7'h07 -> head=3, free_reg=7'h23, num_free=30.
REQ-036 Drive 40 dequeue/retire pairs -> pointers wrap past 63->0 with no lost or duplicated tag; the union of free and mapped tags is always 0..63.

Source files
------------

// File: rtl/free_list.sv
// Physical register free list: 32-entry circular FIFO of free tags with branch checkpoint/restore.
// Define FREE_LIST_DEBUG_EN to expose internal state ports and the overflow assertion.
module free_list (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             retire_en,
    input  logic [6:0]       retire_tag,
    input  logic             checkpoint_en,
    input  logic             branch_incorrect,
`ifdef FREE_LIST_DEBUG_EN
    output logic [31:0][5:0] fl_entries_out,
    output logic [5:0]       head_out,
    output logic [5:0]       tail_out,
`endif
    output logic [6:0]       free_reg,
    output logic             free_valid,
    output logic [5:0]       num_free
);

    localparam int NUM_PHYS_REG = 64;
    localparam int NUM_GEN_REG  = 32;
    localparam int FL_DEPTH     = NUM_PHYS_REG - NUM_GEN_REG;

    logic [5:0] r_entries [FL_DEPTH];
    logic [5:0] r_head;
    logic [5:0] r_tail;
    logic [5:0] r_ckpt_head;

    logic [5:0] w_count;
    logic       w_empty;
    logic       w_full;
    logic       w_deq;
    logic       w_enq;
    logic [5:0] w_head_adv;
    logic       w_unused_ready;

    assign w_unused_ready = retire_tag[6];

    assign w_count = r_tail - r_head;
    assign w_empty = (w_count == 6'd0);
    assign w_full  = (w_count == 6'(FL_DEPTH));

    assign w_deq = enable && !w_empty && !branch_incorrect;
    // A full list can still accept a retire when the head slot is being vacated.
    assign w_enq = retire_en && (!w_full || w_deq);

    assign w_head_adv = r_head + {5'd0, w_deq};

    assign num_free   = w_count;
    assign free_valid = !w_empty;
    assign free_reg   = {1'b0, r_entries[r_head[4:0]]};

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                r_entries[i] <= 6'(NUM_GEN_REG + i);
            end
        end else if (w_enq) begin
            r_entries[r_tail[4:0]] <= retire_tag[5:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_head      <= 6'd0;
            r_tail      <= 6'(FL_DEPTH);
            r_ckpt_head <= 6'd0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + 6'd1;
            end
            if (branch_incorrect) begin
                r_head <= r_ckpt_head;
            end else begin
                r_head <= w_head_adv;
                if (checkpoint_en) begin
                    r_ckpt_head <= w_head_adv;
                end
            end
        end
    end

`ifdef FREE_LIST_DEBUG_EN
    always_comb begin
        for (int i = 0; i < FL_DEPTH; i++) begin
            fl_entries_out[i] = r_entries[i];
        end
    end

    assign head_out = r_head;
    assign tail_out = r_tail;

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(retire_en && w_full && !w_deq))
            else $error("free_list: retire into a full free list");
        end
    end
`endif
`endif

endmodule
